f_fetch_unit: RTL
=================

Name: f_fetch_unit

Overview:
- F-stage fetch engine of the 5-stage MIPS pipeline. It is the consumer of the D-stage next-PC result (D_npc).
- Owns the fetch PC register and issues one instruction-memory request at a time over a req/ack handshake.
- Holds one fetched instruction for D, and applies branch/jump redirects after the delay slot.
- Squashes stale in-flight fetches and flags misaligned or out-of-range fetch addresses (AdEL).

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset
IM_LO, 32'h0000_3000, lowest legal instruction address (inclusive)
IM_HI, 32'h0000_6FFF, highest legal instruction address (inclusive)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  D stage not accepting; F output must hold
D_jump  input  1  D-stage instruction is a branch/jump and advances this cycle; D_npc is valid
D_npc  input  32  redirect target from next-PC logic (pc+8 when branch not taken)
imem_req  output  1  fetch request; level signal, held until ack
imem_addr  output  32  word address of the request; stable while imem_req=1
imem_ack  input  1  one-cycle response pulse; earliest 1 cycle after req rises
imem_rdata  input  32  instruction word; valid with imem_ack
F_valid  output  1  F_instr/F_pc hold an instruction for D
F_pc  output  32  address of F_instr
F_instr  output  32  fetched instruction (0 when F_exc_adel=1)
F_exc_adel  output  1  F_pc misaligned or outside [IM_LO, IM_HI]

Behaviour:
- Reset (synchronous, highest priority, also aborts any in-flight request):
  - F_valid=0, F_pc=RESET_PC, F_instr=0, F_exc_adel=0, imem_req=0, imem_addr=RESET_PC.
  - fetch_pc=RESET_PC, squash=0, state=IDLE.
  - An ack arriving in the reset cycle is ignored.
- consume = F_valid & ~stall. When consume=1, D latches the F outputs at this edge.
- Next-address rule:
  - After a sequential issue, fetch_pc advances to issued_addr+4.
  - When D_jump=1 & ~stall, fetch_pc <= D_npc. This overrides the sequential update in the same cycle.
  - The hazard unit guarantees that D_jump with ~stall only occurs when F_valid=1 (F holds the delay slot). Any violation is undefined.
- FSM:
  - IDLE: no request outstanding. Issue when (~F_valid | consume):
    - if fetch_pc is legal: imem_req=1, imem_addr=fetch_pc, go to WAIT.
    - if fetch_pc is illegal: no memory access; load F next edge with F_valid=1, F_pc=fetch_pc, F_instr=0, F_exc_adel=1; fetch_pc += 4.
  - WAIT: hold imem_req/imem_addr until imem_ack.
    - On ack with squash=0: F_valid=1, F_pc=imem_addr, F_instr=imem_rdata, F_exc_adel=0; imem_req drops; go to IDLE.
    - On ack with squash=1: discard data, clear squash, go to IDLE. The F register is unchanged except for consume clearing it.
- Squash:
  - Set when D_jump & ~stall, state=WAIT, no ack this cycle, and imem_addr != D_npc.
  - If imem_addr == D_npc (branch not taken), the in-flight fetch is kept and fetch_pc <= D_npc+4.
  - If the ack arrives in the same cycle as the redirect: the data is discarded when imem_addr != D_npc; otherwise it is accepted.
- F register update priority: reset > load from ack/AdEL > consume (F_valid<=0) > hold.
  - A load and a consume in the same cycle leave F_valid=1 with the new instruction.
  - Without consume, F is never overwritten, because issue requires F empty or being consumed.
- Legality check: addr[1:0]!=0 or addr<IM_LO or addr>IM_HI. The check uses unsigned compare.
- PC arithmetic is 32-bit, mod 2^32. Wrap past IM_HI naturally yields an AdEL.
- Issue latency:
  - From reset release, imem_req rises one cycle later.
  - With zero-wait memory (ack 1 cycle after req), sustained throughput is one instruction per 2 cycles. This is accepted by design.

Test Plan:
- Reset release, ack 1 cycle after each req, stall=0 -> requests at 0x3000, 0x3004, 0x3008; F_pc follows the same sequence; F_valid pulses with each ack.
- stall=1 held 5 cycles while F holds 0x3004 -> F_pc/F_instr stable; at most one new request is issued, and its ack data is not loaded until stall drops.
- F holds delay slot 0x3010, WAIT on 0x3014, D_jump=1 with D_npc=0x3400 -> 0x3014 ack discarded; next request at 0x3400; no 0x3014 instruction reaches F.
- Same setup but D_npc=0x3014 (not taken) -> in-flight ack accepted; next request at 0x3018.
- D_jump with D_npc=0x3402 -> no imem_req for it; F_valid=1, F_pc=0x3402, F_exc_adel=1, F_instr=0; next fetch at 0x3406, also AdEL.
- reset asserted while in WAIT with ack arriving in the same cycle -> ack ignored; next cycle F_valid=0, imem_req=0; following cycle imem_req=1 at 0x3000.

Source files
------------

// File: rtl/f_fetch_unit.sv
// F-stage fetch engine for the 5-stage MIPS pipeline.
// Owns the fetch PC and keeps at most one instruction-memory request in
// flight over a level req / pulse ack handshake. Holds one instruction for D,
// applies branch/jump redirects after the delay slot, drops wrong-path
// fetches and raises AdEL for misaligned or out-of-range fetch addresses.
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        D_jump,
    input  logic [31:0] D_npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        F_valid,
    output logic [31:0] F_pc,
    output logic [31:0] F_instr,
    output logic        F_exc_adel
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Instruction slot handed to D.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } f_slot_t;

    state_t      state;
    f_slot_t     f_q;
    logic [31:0] fetch_pc;
    logic        squash;

    logic        consume;
    logic        redirect;
    logic        can_issue;
    logic [31:0] cur_addr;
    logic        redirect_hit;
    logic        kill;
    logic        fetch_pc_bad;

    function automatic logic addr_illegal(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI);
    endfunction

    // Handshake terms and redirect resolution.
    // cur_addr is the fetch that is current this cycle: the in-flight
    // request while waiting, or the one about to be issued (or turned into
    // an AdEL) while idle. A redirect whose target equals it is a not-taken
    // branch and keeps it; any other target kills it.
    always_comb begin
        consume      = f_q.valid & ~stall;
        redirect     = D_jump & ~stall;
        can_issue    = ~f_q.valid | consume;
        cur_addr     = (state == S_WAIT) ? imem_addr : fetch_pc;
        redirect_hit = (cur_addr == D_npc);
        kill         = redirect & ~redirect_hit;
        fetch_pc_bad = addr_illegal(fetch_pc);
    end

    // Fetch FSM, fetch PC, squash flag and F slot; reset aborts everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            squash    <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            f_q.valid <= 1'b0;
            f_q.pc    <= RESET_PC;
            f_q.instr <= 32'h0;
            f_q.adel  <= 1'b0;
        end else begin
            // Consume has lowest priority; a load below overrides it.
            if (consume) begin
                f_q.valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (can_issue) begin
                        if (!fetch_pc_bad) begin
                            imem_req  <= 1'b1;
                            imem_addr <= fetch_pc;
                            state     <= S_WAIT;
                            // Issued on the wrong path of a redirect taken
                            // this very cycle: let it complete, drop the data.
                            squash    <= kill;
                        end else if (!kill) begin
                            // Illegal address: no memory access, report AdEL.
                            f_q.valid <= 1'b1;
                            f_q.pc    <= fetch_pc;
                            f_q.instr <= 32'h0;
                            f_q.adel  <= 1'b1;
                        end
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= S_IDLE;
                        squash   <= 1'b0;
                        if (!squash && !kill) begin
                            f_q.valid <= 1'b1;
                            f_q.pc    <= imem_addr;
                            f_q.instr <= imem_rdata;
                            f_q.adel  <= 1'b0;
                        end
                    end else if (kill) begin
                        squash <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Redirect wins over the sequential update. On a not-taken
            // branch the current fetch already covers D_npc, so continue
            // right after it.
            if (redirect) begin
                fetch_pc <= redirect_hit ? (D_npc + 32'd4) : D_npc;
            end
        end
    end

    assign F_valid    = f_q.valid;
    assign F_pc       = f_q.pc;
    assign F_instr    = f_q.instr;
    assign F_exc_adel = f_q.adel;

endmodule
